// File: rtl/carry4_alu2_seq.sv
`default_nettype none
// ============================================================================
// Module   : carry4_alu2_seq
// Purpose  : Issues one LANES-byte operation to an 8-bit ALU lane by lane,
//            chaining carries and assembling the wide result and flags.
//            Optional watchdog: define CARRY4_ALU2_SEQ_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
module carry4_alu2_seq #(
    parameter int LANES = 4
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           req_opcode,
    input  logic                 req_carry,
    input  logic [8*LANES-1:0]   req_operand0,
    input  logic [8*LANES-1:0]   req_operand1,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [8*LANES-1:0]   resp_result,
    output logic                 resp_carry,
    output logic                 resp_zero,
    output logic                 resp_sign,
    output logic                 resp_error,
    output logic                 alu_enable,
    output logic                 alu_write,
    output logic                 alu_strobe,
    output logic                 alu_carryflag,
    output logic [2:0]           alu_opcode,
    output logic [7:0]           alu_operand0,
    output logic [7:0]           alu_operand1,
    input  logic [7:0]           alu_result,
    input  logic                 alu_carry_in,
    input  logic                 alu_zero_in,
    input  logic                 alu_sign_in,
    input  logic                 alu_ready
);

    localparam int                c_W    = 8 * LANES;
    localparam int                c_LW   = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [c_LW-1:0]   c_LAST = c_LW'(LANES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic [c_LW-1:0]     r_lane;
    logic [c_W-1:0]      r_op0;
    logic [c_W-1:0]      r_op1;
    logic [c_W-1:0]      r_acc;
    logic                r_zero;
    logic                r_req_ready;
    logic                r_resp_valid;
    logic [c_W-1:0]      r_resp_result;
    logic                r_resp_carry;
    logic                r_resp_zero;
    logic                r_resp_sign;
    logic                r_alu_en;
    logic                r_alu_strobe;
    logic                r_alu_cf;
    logic [2:0]          r_alu_opc;
    logic [7:0]          r_alu_op0;
    logic [7:0]          r_alu_op1;

    logic [c_LW+2:0]     w_base;
    logic [c_W-1:0]      w_acc_next;
    logic                w_timeout;

    assign w_base = {r_lane, 3'b000};

    always_comb begin
        w_acc_next                = r_acc;
        w_acc_next[w_base +: 8]   = alu_result;
    end

`ifdef CARRY4_ALU2_SEQ_TIMEOUT_EN
    logic [3:0] r_wdog;
    logic       r_resp_error;

    // Fifteenth WAIT cycle without alu_ready is the one where r_wdog reads 14.
    assign w_timeout  = (r_state == S_WAIT) && !alu_ready && (r_wdog == 4'd14);
    assign resp_error = r_resp_error;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wdog       <= 4'd0;
            r_resp_error <= 1'b0;
        end else begin
            if (r_state == S_ISSUE)
                r_wdog <= 4'd0;
            else if (r_state == S_WAIT && !alu_ready)
                r_wdog <= r_wdog + 4'd1;
            if (w_timeout)
                r_resp_error <= 1'b1;
            else if (r_state == S_DONE && resp_ready)
                r_resp_error <= 1'b0;
        end
    end
`else
    assign w_timeout  = 1'b0;
    assign resp_error = 1'b0;
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state       <= S_IDLE;
            r_lane        <= '0;
            r_op0         <= '0;
            r_op1         <= '0;
            r_acc         <= '0;
            r_zero        <= 1'b0;
            r_req_ready   <= 1'b1;
            r_resp_valid  <= 1'b0;
            r_resp_result <= '0;
            r_resp_carry  <= 1'b0;
            r_resp_zero   <= 1'b0;
            r_resp_sign   <= 1'b0;
            r_alu_en      <= 1'b0;
            r_alu_strobe  <= 1'b0;
            r_alu_cf      <= 1'b0;
            r_alu_opc     <= 3'd0;
            r_alu_op0     <= 8'd0;
            r_alu_op1     <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        // Lane 0 goes straight to the ALU; the rest wait in the shifters.
                        r_state      <= S_ISSUE;
                        r_lane       <= '0;
                        r_req_ready  <= 1'b0;
                        r_alu_en     <= 1'b1;
                        r_alu_strobe <= 1'b1;
                        r_alu_opc    <= req_opcode;
                        r_alu_cf     <= req_carry;
                        r_alu_op0    <= req_operand0[7:0];
                        r_alu_op1    <= req_operand1[7:0];
                        r_op0        <= req_operand0 >> 8;
                        r_op1        <= req_operand1 >> 8;
                        r_acc        <= '0;
                        r_zero       <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    r_alu_strobe <= 1'b0;
                    r_state      <= S_WAIT;
                end
                S_WAIT: begin
                    if (alu_ready) begin
                        r_acc  <= w_acc_next;
                        r_zero <= r_zero & alu_zero_in;
                        if (r_lane == c_LAST) begin
                            r_state       <= S_DONE;
                            r_resp_valid  <= 1'b1;
                            r_resp_result <= w_acc_next;
                            r_resp_carry  <= alu_carry_in;
                            r_resp_zero   <= r_zero & alu_zero_in;
                            r_resp_sign   <= alu_sign_in;
                            r_alu_en      <= 1'b0;
                            r_alu_opc     <= 3'd0;
                            r_alu_cf      <= 1'b0;
                            r_alu_op0     <= 8'd0;
                            r_alu_op1     <= 8'd0;
                        end else begin
                            r_state      <= S_ISSUE;
                            r_lane       <= r_lane + c_LW'(1);
                            r_alu_strobe <= 1'b1;
                            r_alu_cf     <= alu_carry_in;
                            r_alu_op0    <= r_op0[7:0];
                            r_alu_op1    <= r_op1[7:0];
                            r_op0        <= r_op0 >> 8;
                            r_op1        <= r_op1 >> 8;
                        end
                    end else if (w_timeout) begin
                        r_state       <= S_DONE;
                        r_resp_valid  <= 1'b1;
                        r_resp_result <= '0;
                        r_resp_carry  <= 1'b0;
                        r_resp_zero   <= 1'b0;
                        r_resp_sign   <= 1'b0;
                        r_alu_en      <= 1'b0;
                        r_alu_opc     <= 3'd0;
                        r_alu_cf      <= 1'b0;
                        r_alu_op0     <= 8'd0;
                        r_alu_op1     <= 8'd0;
                    end
                end
                S_DONE: begin
                    if (resp_ready) begin
                        r_state       <= S_IDLE;
                        r_req_ready   <= 1'b1;
                        r_resp_valid  <= 1'b0;
                        r_resp_result <= '0;
                        r_resp_carry  <= 1'b0;
                        r_resp_zero   <= 1'b0;
                        r_resp_sign   <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready     = r_req_ready;
    assign resp_valid    = r_resp_valid;
    assign resp_result   = r_resp_result;
    assign resp_carry    = r_resp_carry;
    assign resp_zero     = r_resp_zero;
    assign resp_sign     = r_resp_sign;
    assign alu_enable    = r_alu_en;
    assign alu_write     = r_alu_en;
    assign alu_strobe    = r_alu_strobe;
    assign alu_carryflag = r_alu_cf;
    assign alu_opcode    = r_alu_opc;
    assign alu_operand0  = r_alu_op0;
    assign alu_operand1  = r_alu_op1;

endmodule
`default_nettype wire
